// File: rtl/dice_roll_arbiter_pkg.sv
// dice_pkg: shared definitions for the dice roll arbiter.
//   - die select encodings (D4/D6/D8/D20)
//   - die_faces(): number of faces for a die select code
//   - state_t: arbiter FSM states
package dice_pkg;

  localparam logic [1:0] DIE_D4  = 2'b00;
  localparam logic [1:0] DIE_D6  = 2'b01;
  localparam logic [1:0] DIE_D8  = 2'b10;
  localparam logic [1:0] DIE_D20 = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  function automatic logic [7:0] die_faces(input logic [1:0] die);
    logic [7:0] faces;
    case (die)
      DIE_D4:  faces = 8'd4;
      DIE_D6:  faces = 8'd6;
      DIE_D8:  faces = 8'd8;
      default: faces = 8'd20;
    endcase
    return faces;
  endfunction

endpackage

// File: rtl/dice_roll_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin grant.
//   i_req       request vector
//   i_ptr       index with highest priority this cycle
//   o_grant     one-hot grant (first set request at or above i_ptr, wrapping)
//   o_grant_idx binary index of the granted requester
//   o_any       at least one request is set
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [PTR_W-1:0]   o_grant_idx,
  output logic               o_any
);

  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    o_any       = 1'b0;
    // Walk NUM_REQ positions starting at i_ptr; the first hit wins.
    for (int i = 0; i < NUM_REQ; i++) begin
      int idx;
      idx = (int'(i_ptr) + i) % NUM_REQ;
      if (!o_any && i_req[idx]) begin
        o_any        = 1'b1;
        o_grant[idx] = 1'b1;
        o_grant_idx  = PTR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/dice_roll_arbiter.sv
// dice_roll_arbiter: shares one dice_roller among NUM_REQ requesters.
// Grants one request at a time round-robin, issues one roll pulse per die,
// accumulates the rolled values (saturating) and returns the sum.
//
// Handshakes: a transfer happens on a cycle where valid and ready are both
// high. req_valid[i] is held until req_ready[i]; resp_valid is held, with
// resp_id/resp_sum/resp_err stable, until resp_ready.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   req_valid/die/count  per-requester request fields
//   req_ready         one-hot accept pulse (IDLE only)
//   roll_o, die_select_o  roller control
//   rolled_number_i   roller result, valid ROLL_LAT cycles after roll_o
//   resp_*            response channel
//   busy              not IDLE
//   dbg_state         current FSM state
module dice_roll_arbiter
  import dice_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int CNT_W    = 3,
  parameter int SUM_W    = 8,
  parameter int ROLL_LAT = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [2*NUM_REQ-1:0]       req_die,
  input  logic [CNT_W*NUM_REQ-1:0]   req_count,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       roll_o,
  output logic [1:0]                 die_select_o,
  input  logic [7:0]                 rolled_number_i,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [$clog2(NUM_REQ)-1:0] resp_id,
  output logic [SUM_W-1:0]           resp_sum,
  output logic                       resp_err,
  output logic                       busy,
  output logic [1:0]                 dbg_state
);

  localparam int ID_W   = $clog2(NUM_REQ);
  localparam int WAIT_W = $clog2(ROLL_LAT + 1);
  localparam int ACC_W  = ((SUM_W > 8) ? SUM_W : 8) + 1;
  localparam logic [SUM_W-1:0] SUM_MAX = '1;

  state_t              r_state;
  state_t              w_next_state;
  logic [ID_W-1:0]     r_rr_ptr;
  logic [ID_W-1:0]     r_id;
  logic [1:0]          r_die;
  logic [CNT_W-1:0]    r_remain;
  logic [WAIT_W-1:0]   r_wait;
  logic [SUM_W-1:0]    r_sum;
  logic                r_err;

  logic [NUM_REQ-1:0]  w_grant;
  logic [ID_W-1:0]     w_grant_idx;
  logic                w_any;
  logic [1:0]          w_req_die;
  logic [CNT_W-1:0]    w_req_count;
  logic                w_last_wait;
  logic                w_sample_err;
  logic [ACC_W-1:0]    w_acc;
  logic [SUM_W-1:0]    w_sum_next;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (ID_W)
  ) u_rr_arbiter (
    .i_req       (req_valid),
    .i_ptr       (r_rr_ptr),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx),
    .o_any       (w_any)
  );

  assign w_req_die   = req_die[2*int'(w_grant_idx) +: 2];
  assign w_req_count = req_count[CNT_W*int'(w_grant_idx) +: CNT_W];

  // The roller result is sampled only on the final WAIT cycle.
  assign w_last_wait  = (r_state == ST_WAIT) && (r_wait == WAIT_W'(1));
  assign w_sample_err = (rolled_number_i == 8'd0) ||
                        (rolled_number_i > die_faces(r_die));
  // Add in a wider accumulator so overflow is visible, then clamp.
  assign w_acc      = ACC_W'(r_sum) + ACC_W'(rolled_number_i);
  assign w_sum_next = (w_acc > ACC_W'(SUM_MAX)) ? SUM_MAX : w_acc[SUM_W-1:0];

  always_comb begin
    w_next_state = r_state;
    req_ready    = '0;
    roll_o       = 1'b0;
    die_select_o = 2'b00;
    resp_valid   = 1'b0;
    busy         = 1'b1;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (w_any) begin
          req_ready    = w_grant;
          w_next_state = (w_req_count == '0) ? ST_RESP : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        roll_o       = 1'b1;
        die_select_o = r_die;
        w_next_state = ST_WAIT;
      end
      ST_WAIT: begin
        die_select_o = r_die;
        if (w_last_wait) begin
          w_next_state = (r_remain == CNT_W'(1)) ? ST_RESP : ST_ISSUE;
        end
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_rr_ptr <= '0;
      r_id     <= '0;
      r_die    <= 2'b00;
      r_remain <= '0;
      r_wait   <= '0;
      r_sum    <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_id     <= w_grant_idx;
            r_die    <= w_req_die;
            r_remain <= w_req_count;
            r_sum    <= '0;
            r_err    <= 1'b0;
          end
        end
        ST_ISSUE: begin
          r_wait <= WAIT_W'(ROLL_LAT);
        end
        ST_WAIT: begin
          if (w_last_wait) begin
            r_sum    <= w_sum_next;
            r_err    <= r_err | w_sample_err;
            r_remain <= r_remain - CNT_W'(1);
          end else begin
            r_wait <= r_wait - WAIT_W'(1);
          end
        end
        ST_RESP: begin
          // Priority moves to the requester after the one just served.
          if (resp_ready) begin
            r_rr_ptr <= (r_id == ID_W'(NUM_REQ - 1)) ? '0 : r_id + ID_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign resp_id   = r_id;
  assign resp_sum  = r_sum;
  assign resp_err  = r_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_dice_roll_arbiter.sv
module tb_dice_roll_arbiter;
  import dice_pkg::*;

  localparam int NUM_REQ  = 4;
  localparam int CNT_W    = 3;
  localparam int SUM_W    = 8;
  localparam int ROLL_LAT = 1;
  localparam int ID_W     = 2;

  logic                     clk;
  logic                     reset;
  logic [NUM_REQ-1:0]       req_valid;
  logic [2*NUM_REQ-1:0]     req_die;
  logic [CNT_W*NUM_REQ-1:0] req_count;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     roll_o;
  logic [1:0]               die_select_o;
  logic [7:0]               rolled_number_i;
  logic                     resp_valid;
  logic                     resp_ready;
  logic [ID_W-1:0]          resp_id;
  logic [SUM_W-1:0]         resp_sum;
  logic                     resp_err;
  logic                     busy;
  logic [1:0]               dbg_state;

  dice_roll_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .CNT_W    (CNT_W),
    .SUM_W    (SUM_W),
    .ROLL_LAT (ROLL_LAT)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_die         (req_die),
    .req_count       (req_count),
    .req_ready       (req_ready),
    .roll_o          (roll_o),
    .die_select_o    (die_select_o),
    .rolled_number_i (rolled_number_i),
    .resp_valid      (resp_valid),
    .resp_ready      (resp_ready),
    .resp_id         (resp_id),
    .resp_sum        (resp_sum),
    .resp_err        (resp_err),
    .busy            (busy),
    .dbg_state       (dbg_state)
  );

  // ---------------- clock / reset ----------------
  int cyc;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [SUM_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- roller model ----------------
  // Each roll pulse pops the next scripted value; it is presented from the
  // middle of the ISSUE cycle, so it is stable on the sampling edge.
  logic [7:0] roll_q[$];
  int         roll_cyc[$];
  logic [1:0] roll_die[$];
  int         roll_cnt = 0;
  initial begin
    rolled_number_i = 8'd0;
    forever begin
      @(negedge clk);
      if (roll_o === 1'b1) begin
        roll_cnt++;
        roll_cyc.push_back(cyc);
        roll_die.push_back(die_select_o);
        rolled_number_i = (roll_q.size() > 0) ? roll_q.pop_front() : 8'd1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset      = 1'b1;
    req_valid  = '0;
    resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_grant(input int idx, output int t_acc);
    for (int k = 0; k < 100; k++) begin
      #1;
      if (req_ready != '0) break;
      @(negedge clk);
    end
    check($sformatf("grant%0d", idx), 32'(req_ready), 32'(1 << idx));
    t_acc = cyc;
    @(posedge clk);
    #1 req_valid[idx] = 1'b0;
  endtask

  task automatic issue_req(input int idx, input logic [1:0] die, input int cnt, output int t_acc);
    req_die[2*idx +: 2]           = die;
    req_count[CNT_W*idx +: CNT_W] = CNT_W'(cnt);
    req_valid[idx]                = 1'b1;
    wait_grant(idx, t_acc);
  endtask

  task automatic wait_resp(input string tag, input int exp_id, input int exp_err,
                           input int exp_cyc, input int hold, output int t_hs);
    logic [SUM_W-1:0] es;
    es = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    for (int k = 0; k < 200; k++) begin
      if (resp_valid === 1'b1) break;
      @(negedge clk);
    end
    check({tag, "_valid"}, 32'(resp_valid), 32'd1);
    check({tag, "_cycle"}, 32'(cyc), 32'(exp_cyc));
    check({tag, "_id"},    32'(resp_id), 32'(exp_id));
    check({tag, "_sum"},   32'(resp_sum), 32'(es));
    check({tag, "_err"},   32'(resp_err), 32'(exp_err));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, 32'(resp_valid), 32'd1);
      check({tag, "_hold_id"},    32'(resp_id), 32'(exp_id));
      check({tag, "_hold_sum"},   32'(resp_sum), 32'(es));
      check({tag, "_hold_err"},   32'(resp_err), 32'(exp_err));
      check({tag, "_hold_ready"}, 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    t_hs = cyc;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    check({tag, "_drop"}, 32'(resp_valid), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t, ths, rc0;
    req_die   = '0;
    req_count = '0;
    do_reset();

    // Reset state
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_roll",  32'(roll_o), 32'd0);
    check("rst_die",   32'(die_select_o), 32'd0);
    check("rst_valid", 32'(resp_valid), 32'd0);
    check("rst_id",    32'(resp_id), 32'd0);
    check("rst_sum",   32'(resp_sum), 32'd0);
    check("rst_err",   32'(resp_err), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));

    // Single request: D20 x3, rolls 5,17,9 -> 31
    roll_q = '{8'd5, 8'd17, 8'd9};
    roll_cyc.delete();
    roll_die.delete();
    exp_q.push_back(8'd31);
    issue_req(0, DIE_D20, 3, t);
    wait_resp("single", 0, 0, t + 7, 0, ths);
    check("single_nroll", 32'(roll_cyc.size()), 32'd3);
    if (roll_cyc.size() == 3) begin
      check("single_roll1", 32'(roll_cyc[0]), 32'(t + 1));
      check("single_roll2", 32'(roll_cyc[1]), 32'(t + 3));
      check("single_roll3", 32'(roll_cyc[2]), 32'(t + 5));
      check("single_dsel",  32'(roll_die[0]), 32'(DIE_D20));
    end
    check("single_dsel_idle", 32'(die_select_o), 32'd0);

    // Round-robin from rr_ptr=0 with all four requesting
    do_reset();
    roll_q = '{8'd1, 8'd2, 8'd3, 8'd4};
    for (int i = 0; i < NUM_REQ; i++) begin
      req_die[2*i +: 2]           = DIE_D4;
      req_count[CNT_W*i +: CNT_W] = CNT_W'(1);
      exp_q.push_back(SUM_W'(i + 1));
    end
    req_valid = 4'hF;
    for (int i = 0; i < NUM_REQ; i++) begin
      wait_grant(i, t);
      wait_resp($sformatf("rr%0d", i), i, 0, t + 3, 0, ths);
    end

    // Serve req2 alone (rr_ptr -> 3), then req0+req2 -> 0 first, then 2
    roll_q = '{8'd2, 8'd3, 8'd4};
    exp_q.push_back(8'd2);
    issue_req(2, DIE_D6, 1, t);
    wait_resp("rr2_alone", 2, 0, t + 3, 0, ths);
    exp_q.push_back(8'd3);
    exp_q.push_back(8'd4);
    req_valid = 4'b0101;
    wait_grant(0, t);
    wait_resp("rr_wrap0", 0, 0, t + 3, 0, ths);
    wait_grant(2, t);
    wait_resp("rr_wrap2", 2, 0, t + 3, 0, ths);

    // count=0 on req1: no roll, response next cycle
    rc0 = roll_cnt;
    exp_q.push_back(8'd0);
    issue_req(1, DIE_D8, 0, t);
    wait_resp("cnt0", 1, 0, t + 1, 0, ths);
    check("cnt0_norolls", 32'(roll_cnt), 32'(rc0));

    // Out-of-range samples on D4: 7 then 0 -> sum 7, err
    roll_q = '{8'd7, 8'd0};
    exp_q.push_back(8'd7);
    issue_req(3, DIE_D4, 2, t);
    wait_resp("oor", 3, 1, t + 5, 0, ths);

    // Saturation: seven rolls of 255
    roll_q = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255};
    exp_q.push_back(8'd255);
    issue_req(0, DIE_D20, 7, t);
    wait_resp("sat", 0, 1, t + 15, 0, ths);

    // Backpressure with req2 pending: outputs stable, no accept until handshake
    roll_q = '{8'd6, 8'd8};
    exp_q.push_back(8'd6);
    exp_q.push_back(8'd8);
    req_die[2*2 +: 2]           = DIE_D8;
    req_count[CNT_W*2 +: CNT_W] = CNT_W'(1);
    issue_req(1, DIE_D8, 1, t);
    req_valid[2] = 1'b1;
    wait_resp("bp", 1, 0, t + 3, 10, ths);
    check("bp_next_ready", 32'(req_ready), 32'b0100);
    wait_grant(2, t);
    check("bp_accept_cycle", 32'(t), 32'(ths + 1));
    wait_resp("bp_next", 2, 0, t + 3, 0, ths);

    // Reset mid-job during WAIT of a count=4 job
    roll_q = '{8'd1, 8'd2, 8'd3, 8'd4};
    issue_req(3, DIE_D6, 4, t);
    for (int k = 0; k < 20 && cyc < t + 4; k++) @(negedge clk);
    check("mid_state", 32'(dbg_state), 32'(ST_WAIT));
    reset = 1'b1;
    @(negedge clk);
    check("mid_roll",  32'(roll_o), 32'd0);
    check("mid_busy",  32'(busy), 32'd0);
    check("mid_valid", 32'(resp_valid), 32'd0);
    reset = 1'b0;
    roll_q.delete();
    roll_q.push_back(8'd5);
    exp_q.push_back(8'd5);
    issue_req(2, DIE_D6, 1, t);
    wait_resp("post_rst", 2, 0, t + 3, 0, ths);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dice_roll_arbiter.md
Name: dice_roll_arbiter

Overview:
- Shares one dice_roller instance among NUM_REQ requesters.
- Each request names a die type and a dice count. The block arbitrates round-robin and issues one roll pulse per die. It samples and accumulates the rolled values, then returns the sum with a valid/ready response.
- Sits between game-logic requesters and the dice_roller datapath. It is the only driver of the roller's roll and die_select inputs.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- CNT_W, 3, width of dice-count field; max dice per request = 2^CNT_W-1
- SUM_W, 8, width of accumulated sum
- ROLL_LAT, 1, cycles from roll pulse to valid rolled_number (>=1)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high; all state cleared at the clk edge where reset=1
- req_valid  in  NUM_REQ  per-requester request; held until req_ready
- req_die  in  2*NUM_REQ  die select per requester, slice [2i+1:2i]
- req_count  in  CNT_W*NUM_REQ  dice count per requester
- req_ready  out  NUM_REQ  one-hot accept pulse, combinational, IDLE only
- roll_o  out  1  roll pulse to dice_roller
- die_select_o  out  2  die select to dice_roller
- rolled_number_i  in  8  result from dice_roller
- resp_valid  out  1  response valid; held until resp_ready
- resp_ready  in  1  response consumer ready
- resp_id  out  $clog2(NUM_REQ)  requester index of response
- resp_sum  out  SUM_W  accumulated sum
- resp_err  out  1  at least one sample was out of range for the die
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset outputs: req_ready=0, roll_o=0, die_select_o=2'b00, resp_valid=0, resp_id=0, resp_sum=0, resp_err=0, busy=0. FSM=IDLE, rr_ptr=0.
- Die faces: 00->4, 01->6, 10->8, 11->20.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, arbitration:
  - If any req_valid is high, the winner is the first set bit searching from rr_ptr upward modulo NUM_REQ.
  - req_ready[winner]=1 in the same cycle.
  - Latch id, die and count; clear sum and err.
  - Next state is ISSUE, or RESP if count=0 (sum 0, no rolls issued).
- ISSUE: roll_o=1 for exactly one cycle. Next state is WAIT with wait counter=ROLL_LAT.
- WAIT:
  - roll_o=0. die_select_o holds the latched die throughout ISSUE and WAIT.
  - On the last WAIT cycle, sample rolled_number_i, add it to sum and decrement remaining.
  - If remaining becomes 0, go to RESP; otherwise go to ISSUE.
- Error and saturation:
  - A sample equal to 0 or greater than faces sets err; the value is still added.
  - The sum saturates at 2^SUM_W-1 and never wraps.
- RESP:
  - resp_valid=1, with resp_id, resp_sum and resp_err stable while valid.
  - On resp_valid & resp_ready: rr_ptr=(id+1) mod NUM_REQ and next state is IDLE.
  - resp_valid deasserts the next cycle.
- Timing: request accepted at cycle T gives first roll_o at T+1 and resp_valid at T+1+n*(1+ROLL_LAT). Minimum gap between consecutive accepts is one IDLE cycle after the handshake.
- Requests arriving during a busy job are not accepted; req_ready stays 0 until IDLE.
- Changes to req_die/req_count after accept have no effect on the current job.
- Reset mid-job: roll_o drops at the reset edge, the job is discarded (no response), rr_ptr=0.
- die_select_o is 2'b00 in IDLE and RESP.

Decomposition:
- Shared package dice_pkg holds:
  - die select encodings (D4=2'b00, D6=2'b01, D8=2'b10, D20=2'b11)
  - a faces lookup function
  - the FSM state enum
- Sub-module rr_arbiter (NUM_REQ request vector plus rr_ptr in, one-hot grant out, combinational) is natural and reusable.

Test Plan:
- Single request: req0 die=11, count=3, roller model returns 5,17,9 -> roll_o pulses at T+1, T+3, T+5; resp_valid at T+7 with id=0, sum=31, err=0.
- Round-robin: req0..req3 all valid, count=1, after reset -> grant order 0,1,2,3. Re-assert req0 and req2 while rr_ptr=3 -> next grant 0, then 2.
- count=0 on req1 -> no roll_o pulse, resp_valid the cycle after accept with sum=0, err=0.
- Out-of-range: die=00, model returns 7 then 0 -> resp_err=1, sum=7. Model returns 255 x7 with count=7 -> sum saturates at 255.
- Backpressure: hold resp_ready=0 for 10 cycles -> resp_valid, id, sum and err stable, no new req_ready. Release -> IDLE next cycle, new accept the cycle after.
- Reset mid-job: assert reset during WAIT of a count=4 job -> next cycle roll_o=0, busy=0, resp_valid=0. A subsequent request from req2 is granted first, since rr_ptr=0 and no other request is pending.
